// File: rtl/mul_seq.sv
// Iterative shift-and-add multiplier that sequences an external combinational ALU.
// It adds one partial product per cycle and returns the low N bits of M*Q.
module mul_seq #(
  parameter int          N       = 64,
  parameter logic [3:0]  ADD_CTL = 4'b0010
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] multiplicand,
  input  logic [N-1:0] multiplier,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product,
  output logic         product_zero,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [3:0]   alu_ctl,
  input  logic [N-1:0] alu_result,
  input  logic         alu_zero
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [N-1:0]  m_q, m_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  product_q, product_d;
  logic          product_zero_q, product_zero_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      m_q            <= '0;
      q_q            <= '0;
      count_q        <= '0;
      product_q      <= '0;
      product_zero_q <= 1'b1;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      m_q            <= m_d;
      q_q            <= q_d;
      count_q        <= count_d;
      product_q      <= product_d;
      product_zero_q <= product_zero_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    m_d            = m_q;
    q_d            = q_q;
    count_d        = count_q;
    product_d      = product_q;
    product_zero_d = product_zero_q;
    alu_a          = '0;
    alu_b          = '0;
    alu_ctl        = ADD_CTL;

    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          m_d     = multiplicand;
          q_d     = multiplier;
          count_d = '0;
          if (multiplier != '0) begin
            state_d = ITER;
          end else begin
            // Zero multiplier skips iteration; the product is trivially zero.
            state_d        = DONE;
            product_d      = '0;
            product_zero_d = 1'b1;
          end
        end
      end

      ITER: begin
        alu_a   = acc_q;
        alu_b   = q_q[0] ? m_q : '0;
        acc_d   = alu_result;
        m_d     = m_q << 1;
        q_d     = q_q >> 1;
        count_d = count_q + CW'(1);
        // Stop as soon as no set multiplier bits remain above the current one.
        if (((q_q >> 1) == '0) || (count_q == CW'(N - 1))) begin
          state_d        = DONE;
          product_d      = alu_result;
          product_zero_d = alu_zero;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy         = (state_q == ITER) || (state_q == DONE);
  assign done         = (state_q == DONE);
  assign product      = product_q;
  assign product_zero = product_zero_q;

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed and random multiplies against an
// arithmetic reference (M*Q mod 2^64, latency from the multiplier's top set bit).
module tb_mul_seq;

  localparam int N = 64;
  localparam logic [3:0] ADD_CTL = 4'b0010;

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] multiplicand;
  logic [N-1:0] multiplier;
  logic         busy;
  logic         done;
  logic [N-1:0] product;
  logic         product_zero;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [3:0]   alu_ctl;
  logic [N-1:0] alu_result;
  logic         alu_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [N-1:0] exp_prod;

  mul_seq #(.N(N), .ADD_CTL(ADD_CTL)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product),
    .product_zero (product_zero),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_ctl      (alu_ctl),
    .alu_result   (alu_result),
    .alu_zero     (alu_zero)
  );

  // Stand-in for the datapath ALU: combinational adder with zero flag.
  assign alu_result = (alu_ctl == ADD_CTL) ? (alu_a + alu_b) : '0;
  assign alu_zero   = (alu_result == '0);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply and check every cycle until one cycle past done.
  // With inject set, a 1*1 start is pulsed in ITER cycle 2 and in the DONE cycle.
  task automatic run_mul(input logic [N-1:0] m, input logic [N-1:0] q, input bit inject);
    int h;
    int lat;
    logic [N-1:0] acc_exp;
    logic [N-1:0] b_exp;
    logic [N-1:0] prev;
    logic [N-1:0] full;
    h = -1;
    for (int j = 0; j < N; j++) if (q[j]) h = j;
    lat  = (h < 0) ? 1 : h + 2;
    full = m * q;
    prev = exp_prod;
    acc_exp = '0;

    start = 1'b1;
    multiplicand = m;
    multiplier   = q;
    step();
    start = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      chk("busy", {63'd0, busy}, 64'd1);
      chk("done", {63'd0, done}, (k == lat) ? 64'd1 : 64'd0);
      chk("alu_ctl", {60'd0, alu_ctl}, {60'd0, ADD_CTL});
      if (k < lat) begin
        b_exp = q[k-1] ? (m << (k - 1)) : '0;
        chk("alu_a", alu_a, acc_exp);
        chk("alu_b", alu_b, b_exp);
        chk("product_held", product, prev);
        acc_exp = acc_exp + b_exp;
      end else begin
        chk("alu_a_idle", alu_a, '0);
        chk("product", product, full);
        chk("product_zero", {63'd0, product_zero}, (full == '0) ? 64'd1 : 64'd0);
      end
      if (inject && (k == 2 || k == lat)) begin
        start = 1'b1;
        multiplicand = 64'd1;
        multiplier   = 64'd1;
      end
      step();
      start = 1'b0;
    end
    exp_prod = full;
    $display("mul M=%h Q=%h -> product=%h done_cycle=%0d", m, q, product, lat);
    chk("busy_after", {63'd0, busy}, 64'd0);
    chk("done_after", {63'd0, done}, 64'd0);
    chk("product_kept", product, full);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    multiplicand = '0;
    multiplier = '0;
    exp_prod = '0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_product", product, '0);
    chk("rst_pzero", {63'd0, product_zero}, 64'd1);
    step();
    step();
    reset = 1'b0;
    step();

    // Reset mid-ITER of 7*9, then 2*3.
    start = 1'b1;
    multiplicand = 64'd7;
    multiplier = 64'd9;
    step();
    start = 1'b0;
    step();
    chk("iter_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    chk("midrst_done", {63'd0, done}, 64'd0);
    chk("midrst_product", product, '0);
    chk("midrst_pzero", {63'd0, product_zero}, 64'd1);
    step();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("no_done_after_rst", {63'd0, done}, 64'd0);
      step();
    end
    $display("reset mid-ITER: product=%h product_zero=%0d", product, product_zero);
    exp_prod = '0;
    run_mul(64'd2, 64'd3, 1'b0);

    run_mul(64'd3, 64'd5, 1'b0);
    run_mul(64'h1234, 64'd0, 1'b0);
    run_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1'b0);
    run_mul(64'h1_0000_0000, 64'h1_0000_0000, 1'b0);
    run_mul(64'd6, 64'd7, 1'b1);
    run_mul(64'd1, 64'd1, 1'b0);

    for (int r = 0; r < 10; r++) begin
      logic [N-1:0] rm;
      logic [N-1:0] rq;
      rm = {$urandom, $urandom};
      rq = {$urandom, $urandom} >> $urandom_range(0, 63);
      run_mul(rm, rq, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
